uart_bus_sequencer: RTL and testbench

//  Host-side bus master for the uart_verif host port (C_nD/n_RD/n_WR/n_CS/DATA_IN/DATA_OUT).

---
 rtl/uart_bus_sequencer_if.sv | 37 +++
 rtl/uart_bus_sequencer.sv | 163 ++++++++++++++++
 tb/tb_uart_bus_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_sequencer_if.sv
// Host-port bundle between uart_bus_sequencer and its clients/UART: request streams
// (config, TX, RX) plus the chip-select/strobe bus to the UART host port.
interface uart_bus_sequencer_if;
   logic       cfg_valid;
   logic [7:0] cfg_data;
   logic       cfg_ready;
   logic       cfg_done;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       busy;
   logic       uart_C_nD;
   logic       uart_n_RD;
   logic       uart_n_WR;
   logic       uart_n_CS;
   logic [7:0] uart_DATA_IN;
   logic [7:0] uart_DATA_OUT;
   logic       uart_Rx_RDY;
   logic       uart_Tx_RDY;

   modport master (
      input  cfg_valid, cfg_data, tx_valid, tx_data, rx_ready,
      input  uart_DATA_OUT, uart_Rx_RDY, uart_Tx_RDY,
      output cfg_ready, cfg_done, tx_ready, rx_valid, rx_data, busy,
      output uart_C_nD, uart_n_RD, uart_n_WR, uart_n_CS, uart_DATA_IN
   );

   modport slave (
      output cfg_valid, cfg_data, tx_valid, tx_data, rx_ready,
      output uart_DATA_OUT, uart_Rx_RDY, uart_Tx_RDY,
      input  cfg_ready, cfg_done, tx_ready, rx_valid, rx_data, busy,
      input  uart_C_nD, uart_n_RD, uart_n_WR, uart_n_CS, uart_DATA_IN
   );
endinterface

// File: rtl/uart_bus_sequencer.sv
// Host-side bus master for the UART host port: arbitrates config/TX/RX requests
// (config first, RX/TX round-robin) into timed n_CS/n_WR/n_RD cycles.
module uart_bus_sequencer #(
   parameter logic [7:0]  CFG_DEFAULT   = 8'h14,
   parameter bit          AUTO_CFG      = 1'b1,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned GAP_CYCLES    = 4
) (
   input logic                   clk,
   input logic                   rst,
   uart_bus_sequencer_if.master  bus
);

   localparam int unsigned CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] STROBE_LOAD  = CW'(STROBE_CYCLES - 1);
   // The IDLE grant cycle supplies the last n_CS-high gap cycle, so RECOVER is one shorter.
   localparam logic [CW-1:0] RECOVER_LOAD = CW'((GAP_CYCLES >= 2) ? (GAP_CYCLES - 2) : 0);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_e;
   typedef enum logic [1:0] {ACC_CFG, ACC_TX, ACC_RX} acc_e;

   state_e        state_q, state_d;
   acc_e          acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    din_q, din_d;
   logic          auto_q, auto_d;
   logic          rr_tx_q, rr_tx_d;
   logic          cfg_done_q, cfg_done_d;
   logic          rx_valid_q, rx_valid_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          n_cs_q, n_cs_d;
   logic          n_wr_q, n_wr_d;
   logic          n_rd_q, n_rd_d;
   logic          cnd_q, cnd_d;
   logic          cfg_ready, tx_ready;
   logic          rx_elig, tx_elig;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= ACC_CFG;
         cnt_q      <= '0;
         din_q      <= '0;
         auto_q     <= AUTO_CFG;
         rr_tx_q    <= 1'b0;
         cfg_done_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         n_cs_q     <= 1'b1;
         n_wr_q     <= 1'b1;
         n_rd_q     <= 1'b1;
         cnd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         din_q      <= din_d;
         auto_q     <= auto_d;
         rr_tx_q    <= rr_tx_d;
         cfg_done_q <= cfg_done_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         n_cs_q     <= n_cs_d;
         n_wr_q     <= n_wr_d;
         n_rd_q     <= n_rd_d;
         cnd_q      <= cnd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      din_d      = din_q;
      auto_d     = auto_q;
      rr_tx_d    = rr_tx_q;
      cfg_done_d = cfg_done_q;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      cfg_ready  = 1'b0;
      tx_ready   = 1'b0;

      rx_elig = cfg_done_q & bus.uart_Rx_RDY & ~rx_valid_q;
      tx_elig = cfg_done_q & bus.tx_valid & bus.uart_Tx_RDY;

      if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (auto_q) begin
               acc_d   = ACC_CFG;
               din_d   = CFG_DEFAULT;
               auto_d  = 1'b0;
               state_d = SETUP;
            end else if (bus.cfg_valid) begin
               acc_d     = ACC_CFG;
               din_d     = bus.cfg_data;
               cfg_ready = 1'b1;
               state_d   = SETUP;
            end else if (rx_elig && (!tx_elig || !rr_tx_q)) begin
               acc_d   = ACC_RX;
               rr_tx_d = 1'b1;
               state_d = SETUP;
            end else if (tx_elig) begin
               acc_d    = ACC_TX;
               din_d    = bus.tx_data;
               tx_ready = 1'b1;
               rr_tx_d  = 1'b0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = STROBE_LOAD;
            state_d = STROBE;
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               if (acc_q == ACC_RX) begin
                  rx_data_d  = bus.uart_DATA_OUT;
                  rx_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            if (acc_q == ACC_CFG) cfg_done_d = 1'b1;
            if (GAP_CYCLES >= 2) begin
               cnt_d   = RECOVER_LOAD;
               state_d = RECOVER;
            end else begin
               state_d = IDLE;
            end
         end
         RECOVER: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase

      // Bus pins are registered from the next state so they never glitch.
      n_cs_d = !(state_d inside {SETUP, STROBE, HOLD});
      n_wr_d = !((state_d == STROBE) && (acc_d != ACC_RX));
      n_rd_d = !((state_d == STROBE) && (acc_d == ACC_RX));
      cnd_d  = n_cs_d ? 1'b1 : (acc_d == ACC_CFG);
   end

   assign bus.cfg_ready    = cfg_ready;
   assign bus.tx_ready     = tx_ready;
   assign bus.cfg_done     = cfg_done_q;
   assign bus.rx_valid     = rx_valid_q;
   assign bus.rx_data      = rx_data_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.uart_n_CS    = n_cs_q;
   assign bus.uart_n_WR    = n_wr_q;
   assign bus.uart_n_RD    = n_rd_q;
   assign bus.uart_C_nD    = cnd_q;
   assign bus.uart_DATA_IN = din_q;

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Directed self-checking bench for uart_bus_sequencer at default parameters.
module tb_uart_bus_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_bus_sequencer_if bif ();

   uart_bus_sequencer #(
      .CFG_DEFAULT   (8'h14),
      .AUTO_CFG      (1'b1),
      .STROBE_CYCLES (2),
      .GAP_CYCLES    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int         cs_low, wr_low, rd_low, txr_cnt, cfgr_cnt;
   logic       wr_cnd, rd_cnd;
   logic [7:0] wr_din;
   logic [7:0] kq[$];
   int         tq[$];
   logic [7:0] dq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Observe n cycles; record each transaction kind (R/T/C) at its first strobe cycle.
   task automatic run_window(input int n, input bit drop_tx, input bit drop_cfg);
      logic prev_strobe, strobe, tx_seen, cfg_seen;
      cs_low = 0; wr_low = 0; rd_low = 0; txr_cnt = 0; cfgr_cnt = 0;
      wr_cnd = 1'bx; rd_cnd = 1'bx; wr_din = 8'hxx;
      kq.delete(); tq.delete(); dq.delete();
      prev_strobe = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         tx_seen  = bif.tx_ready;
         cfg_seen = bif.cfg_ready;
         if (!bif.uart_n_CS) cs_low++;
         if (!bif.uart_n_WR) begin
            wr_low++;
            wr_cnd = bif.uart_C_nD;
            wr_din = bif.uart_DATA_IN;
         end
         if (!bif.uart_n_RD) begin
            rd_low++;
            rd_cnd = bif.uart_C_nD;
         end
         strobe = !bif.uart_n_WR || !bif.uart_n_RD;
         if (strobe && !prev_strobe) begin
            kq.push_back(!bif.uart_n_RD ? 8'h52 : (bif.uart_C_nD ? 8'h43 : 8'h54));
            tq.push_back(i);
            dq.push_back(bif.uart_DATA_IN);
         end
         prev_strobe = strobe;
         if (tx_seen)  txr_cnt++;
         if (cfg_seen) cfgr_cnt++;
         @(posedge clk);
         #1;
         if (drop_tx && tx_seen)   bif.tx_valid  = 1'b0;
         if (drop_cfg && cfg_seen) bif.cfg_valid = 1'b0;
      end
   endtask

   initial begin
      bit found;
      bif.cfg_valid = 1'b0; bif.cfg_data = 8'h00;
      bif.tx_valid = 1'b0;  bif.tx_data = 8'h00;
      bif.rx_ready = 1'b0;  bif.uart_DATA_OUT = 8'h00;
      bif.uart_Rx_RDY = 1'b0; bif.uart_Tx_RDY = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_ncs",  bif.uart_n_CS, 1);
      check("rst_nwr",  bif.uart_n_WR, 1);
      check("rst_nrd",  bif.uart_n_RD, 1);
      check("rst_cnd",  bif.uart_C_nD, 1);
      check("rst_din",  bif.uart_DATA_IN, 8'h00);
      check("rst_busy", bif.busy, 0);
      check("rst_done", bif.cfg_done, 0);
      check("rst_rxv",  bif.rx_valid, 0);

      // 1: auto-config after reset
      @(negedge clk) rst = 1'b0;
      tick();
      check("t1_setup_ncs", bif.uart_n_CS, 0);
      check("t1_setup_nwr", bif.uart_n_WR, 1);
      check("t1_setup_cnd", bif.uart_C_nD, 1);
      check("t1_setup_din", bif.uart_DATA_IN, 8'h14);
      check("t1_busy",      bif.busy, 1);
      tick();
      check("t1_strobe1_nwr", bif.uart_n_WR, 0);
      tick();
      check("t1_strobe2_nwr", bif.uart_n_WR, 0);
      check("t1_strobe2_nrd", bif.uart_n_RD, 1);
      tick();
      check("t1_hold_nwr",  bif.uart_n_WR, 1);
      check("t1_hold_ncs",  bif.uart_n_CS, 0);
      check("t1_hold_done", bif.cfg_done, 0);
      tick();
      check("t1_rec_ncs",  bif.uart_n_CS, 1);
      check("t1_rec_done", bif.cfg_done, 1);
      run_window(10, 1'b0, 1'b0);
      check("t1_quiet_cs", cs_low, 0);

      // 2: single TX write
      bif.tx_valid = 1'b1; bif.tx_data = 8'h68; bif.uart_Tx_RDY = 1'b1;
      run_window(12, 1'b1, 1'b0);
      check("t2_txready", txr_cnt, 1);
      check("t2_wr_low",  wr_low, 2);
      check("t2_cs_low",  cs_low, 4);
      check("t2_cnd",     wr_cnd, 0);
      check("t2_din",     wr_din, 8'h68);
      check("t2_rd_low",  rd_low, 0);

      // 3: TX waits for Tx_RDY
      bif.tx_valid = 1'b1; bif.tx_data = 8'h55; bif.uart_Tx_RDY = 1'b0;
      run_window(50, 1'b1, 1'b0);
      check("t3_wait_cs", cs_low, 0);
      check("t3_wait_tr", txr_cnt, 0);
      bif.uart_Tx_RDY = 1'b1;
      #1;
      check("t3_grant_now", bif.tx_ready, 1);
      run_window(12, 1'b1, 1'b0);
      check("t3_wr_low", wr_low, 2);
      check("t3_din",    wr_din, 8'h55);

      // 4: RX read, held while output register full
      bif.uart_Rx_RDY = 1'b1; bif.uart_DATA_OUT = 8'h71; bif.rx_ready = 1'b0;
      run_window(20, 1'b0, 1'b0);
      check("t4_rd_low",  rd_low, 2);
      check("t4_rd_cnd",  rd_cnd, 0);
      check("t4_nreads",  kq.size(), 1);
      check("t4_rxv",     bif.rx_valid, 1);
      check("t4_rxd",     bif.rx_data, 8'h71);
      bif.rx_ready = 1'b1; bif.uart_DATA_OUT = 8'h72;
      tick();
      check("t4_rxv_drop", bif.rx_valid, 0);
      bif.rx_ready = 1'b0;
      run_window(10, 1'b0, 1'b0);
      check("t4_rd2_low", rd_low, 2);
      check("t4_rxv2",    bif.rx_valid, 1);
      check("t4_rxd2",    bif.rx_data, 8'h72);
      bif.uart_Rx_RDY = 1'b0; bif.rx_ready = 1'b1;
      tick();
      bif.rx_ready = 1'b1;

      // 5: round-robin (last grant was RX, so TX goes first), then config preempts
      bif.uart_Rx_RDY = 1'b1; bif.tx_valid = 1'b1; bif.tx_data = 8'h33; bif.uart_Tx_RDY = 1'b1;
      run_window(33, 1'b0, 1'b0);
      check("t5_count", kq.size(), 4);
      check("t5_k0", kq[0], 8'h54);
      check("t5_k1", kq[1], 8'h52);
      check("t5_k2", kq[2], 8'h54);
      check("t5_k3", kq[3], 8'h52);
      check("t5_sp1", tq[1] - tq[0], 8);
      check("t5_sp2", tq[2] - tq[1], 8);
      check("t5_sp3", tq[3] - tq[2], 8);
      bif.cfg_valid = 1'b1; bif.cfg_data = 8'h2B;
      run_window(20, 1'b0, 1'b1);
      check("t5_cfg_ready", cfgr_cnt, 1);
      check("t5_c_k0",  kq[0], 8'h54);
      check("t5_c_k1",  kq[1], 8'h43);
      check("t5_c_din", dq[1], 8'h2B);
      bif.uart_Rx_RDY = 1'b0; bif.tx_valid = 1'b0;
      run_window(12, 1'b0, 1'b0);
      bif.rx_ready = 1'b0;

      // 6: reset during TX strobe
      bif.tx_valid = 1'b1; bif.tx_data = 8'h99; bif.uart_Tx_RDY = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk);
         #1;
         if (!bif.uart_n_WR) found = 1'b1;
      end
      check("t6_wr_seen", found, 1);
      rst = 1'b1;
      #1;
      check("t6_nwr_async", bif.uart_n_WR, 1);
      check("t6_ncs_async", bif.uart_n_CS, 1);
      check("t6_din_async", bif.uart_DATA_IN, 8'h00);
      check("t6_busy",      bif.busy, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      run_window(12, 1'b1, 1'b0);
      check("t6_first_cfg", kq[0], 8'h43);
      check("t6_cfg_din",   dq[0], 8'h14);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
